hilo_muldiv: RTL

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: iterative radix-2 mult/multu/div/divu plus mthi/mtlo/mfhi/mflo.
// One operand step per cycle; the execute stage is stalled through Busy while a mul/div runs.
module hilo_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Op_valid,
    input  logic [5:0]        Exe_opcode,
    input  logic [5:0]        Function_opcode,
    input  logic [DATA_W-1:0] Read_data_1,
    input  logic [DATA_W-1:0] Read_data_2,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic [DATA_W-1:0] Hilo_read_data,
    output logic              Busy,
    output logic              Done
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && (v < 0)) return DATA_W'(-v);
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign_wide(input logic [2*DATA_W-1:0] v,
                                                            input logic neg);
        return neg ? -v : v;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                is_div_q, is_div_d;
    logic                neg_q_q, neg_q_d;
    logic                neg_r_q, neg_r_d;
    logic                dz_q, dz_d;

    logic                issue;
    logic                op_signed;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_rem_sh;
    logic [DATA_W:0]     div_diff;

    assign Busy = (state_q != IDLE);
    assign Done = (state_q == FIX);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        issue     = Op_valid && (Exe_opcode == 6'b000000) && !Busy;
        op_signed = ~Function_opcode[0];
    end

    // Datapath step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                   + (acc_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
        div_rem_sh = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff   = div_rem_sh - {1'b0, b_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    case (Function_opcode)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            is_div_d = Function_opcode[1];
                            neg_q_d  = op_signed &
                                       (Read_data_1[DATA_W-1] ^ Read_data_2[DATA_W-1]);
                            neg_r_d  = op_signed & Read_data_1[DATA_W-1];
                            b_d      = magnitude(Read_data_2, op_signed);
                            if (Function_opcode[1] && (Read_data_2 == '0)) begin
                                // Divide by zero bypasses iteration with a fixed result
                                acc_d   = {Read_data_1, {DATA_W{1'b1}}};
                                dz_d    = 1'b1;
                                state_d = FIX;
                            end else begin
                                acc_d   = {{DATA_W{1'b0}}, magnitude(Read_data_1, op_signed)};
                                dz_d    = 1'b0;
                                cnt_d   = CNT_W'(DATA_W - 1);
                                state_d = CALC;
                            end
                        end
                        F_MTHI:  hi_d = Read_data_1;
                        F_MTLO:  lo_d = Read_data_1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_diff[DATA_W]) begin
                        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {div_rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    {hi_d, lo_d} = acc_q;
                end else if (is_div_q) begin
                    lo_d = apply_sign(acc_q[DATA_W-1:0], neg_q_q);
                    hi_d = apply_sign(acc_q[2*DATA_W-1:DATA_W], neg_r_q);
                end else begin
                    {hi_d, lo_d} = apply_sign_wide(acc_q, neg_q_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Hilo_read_data = '0;
        if (issue && (Function_opcode == F_MFHI)) begin
            Hilo_read_data = hi_q;
        end else if (issue && (Function_opcode == F_MFLO)) begin
            Hilo_read_data = lo_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand/iteration state is always rewritten at issue, so it carries no reset
    always_ff @(posedge clock) begin
        acc_q    <= acc_d;
        b_q      <= b_d;
        is_div_q <= is_div_d;
        neg_q_q  <= neg_q_d;
        neg_r_q  <= neg_r_d;
        dz_q     <= dz_d;
    end

endmodule
